mac_ctrl: RTL and testbench



---
 rtl/mac_pkg.sv | 19 +
 rtl/mac.sv | 25 ++
 rtl/mac_ctrl.sv | 116 +++++++++++
 tb/tb_mac_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared widths and state encoding for the dot-product MAC controller.
package mac_pkg;

  localparam int BW_DEF      = 4;
  localparam int PSUM_BW_DEF = 16;
  localparam int LEN_BW_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Every state other than IDLE belongs to an active job.
  function automatic logic is_busy(input state_t s);
    return (s != ST_IDLE);
  endfunction

endpackage

// File: rtl/mac.sv
// Combinational multiply-add: out = a*b + c, with a unsigned and b signed.
// Both operands are widened to the result width first, so the product and
// the sum wrap modulo 2^psum_bw.
module mac
  import mac_pkg::*;
#(
  parameter int bw      = BW_DEF,
  parameter int psum_bw = PSUM_BW_DEF
) (
  input  logic [bw-1:0]      a,
  input  logic [bw-1:0]      b,
  input  logic [psum_bw-1:0] c,
  output logic [psum_bw-1:0] out
);

  logic [psum_bw-1:0] a_ext;
  logic [psum_bw-1:0] b_ext;

  // Zero-extend the activation and sign-extend the weight. The low psum_bw
  // bits of the product are the same for signed and unsigned multiplication.
  assign a_ext = {{(psum_bw-bw){1'b0}}, a};
  assign b_ext = {{(psum_bw-bw){b[bw-1]}}, b};
  assign out   = (a_ext * b_ext) + c;

endmodule

// File: rtl/mac_ctrl.sv
// Dot-product job controller. It accepts a job length on start, consumes len
// (a,b) pairs through a valid/ready handshake, accumulates them through one
// mac instance, and holds the result until the consumer accepts it.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start; outputs quiet
// RUN     | in_ready high; each valid pair is accumulated and counted
// DONE    | out_valid high with the final sum; waits for out_ready
module mac_ctrl
  import mac_pkg::*;
#(
  parameter int bw      = BW_DEF,
  parameter int psum_bw = PSUM_BW_DEF,
  parameter int len_bw  = LEN_BW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [len_bw-1:0]  len,
  output logic               busy,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [bw-1:0]      in_a,
  input  logic [bw-1:0]      in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [psum_bw-1:0] out_psum
);

  state_t state;
  state_t state_nxt;

  logic [psum_bw-1:0] acc;
  logic [psum_bw-1:0] acc_nxt;
  logic [psum_bw-1:0] mac_out;
  logic [len_bw-1:0]  cnt;
  logic [len_bw-1:0]  cnt_nxt;
  logic [len_bw-1:0]  cnt_inc;
  logic [len_bw-1:0]  len_q;
  logic [len_bw-1:0]  len_nxt;

  mac #(
    .bw      (bw),
    .psum_bw (psum_bw)
  ) u_mac (
    .a   (in_a),
    .b   (in_b),
    .c   (acc),
    .out (mac_out)
  );

  assign cnt_inc = cnt + 1'b1;

  // State and datapath registers; reset clears the job entirely, so an
  // aborted job leaves nothing behind for the next one.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      acc   <= '0;
      cnt   <= '0;
      len_q <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      len_q <= len_nxt;
    end
  end

  // Next-state and datapath update; start is only looked at in IDLE, so a
  // start coinciding with the output handshake is dropped.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    len_nxt   = len_q;
    case (state)
      ST_IDLE: begin
        if (start) begin
          acc_nxt   = '0;
          cnt_nxt   = '0;
          len_nxt   = len;
          state_nxt = (len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        // in_ready is high for the whole of RUN, so in_valid alone marks
        // a consumed pair.
        if (in_valid) begin
          acc_nxt = mac_out;
          cnt_nxt = cnt_inc;
          if (cnt_inc == len_q) begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs decode the registered state only; there are no paths from
  // in_valid or out_ready.
  assign busy      = is_busy(state);
  assign in_ready  = (state == ST_RUN);
  assign out_valid = (state == ST_DONE);
  assign out_psum  = out_valid ? acc : '0;

endmodule

// File: tb/tb_mac_ctrl.sv
// Self-checking bench for mac_ctrl: directed jobs plus randomized jobs,
// compared against a job-level model (sum of products, cycle bookkeeping).
module tb_mac_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  len;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_a;
  logic [3:0]  in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_psum;

  int n_tests = 0;
  int n_fail  = 0;

  int pa [256];
  int pb [256];
  bit vpat [4096];

  mac_ctrl #(.bw(4), .psum_bw(16), .len_bw(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_psum  (out_psum)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Dot product of the first n pairs, wrapped to 16 bits.
  function automatic logic [15:0] model_sum(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += pa[i] * pb[i];
    return 16'(s);
  endfunction

  task automatic fill_vpat_ones();
    for (int i = 0; i < 4096; i++) vpat[i] = 1'b1;
  endtask

  // Runs one job starting in IDLE, just after a clock edge. vpat[k] is the
  // in_valid planned for the cycle after edge k. The model tracks which
  // cycles are RUN and which pairs are consumed, independent of the DUT.
  task automatic do_job(input int n, input int hold, output int lat, output logic [15:0] res);
    logic [15:0] exp_sum;
    bit run;
    bit done;
    bit consumed;
    int mcnt;
    int k;
    exp_sum = model_sum(n);
    run = 1'b0; done = 1'b0; mcnt = 0; k = 0;
    start = 1'b1; len = 8'(n); out_ready = 1'b0;
    in_valid = 1'b1; in_a = 4'(pa[0]); in_b = 4'(pb[0]);
    while (!done) begin
      consumed = run && in_valid;
      tick(); k++;
      if (k == 1) begin
        run  = (n > 0);
        done = (n == 0);
      end else if (consumed) begin
        mcnt++;
        if (mcnt == n) begin
          run  = 1'b0;
          done = 1'b1;
        end
      end
      check("job_in_ready", in_ready, run);
      check("job_out_valid", out_valid, done);
      check("job_busy", busy, 1);
      if (!done) check("job_psum_quiet", out_psum, 0);
      start = 1'($urandom_range(0, 1));
      len   = 8'($urandom);
      if (mcnt < n) in_valid = vpat[k];
      else in_valid = 1'b0;
      if (in_valid) begin
        in_a = 4'(pa[mcnt]);
        in_b = 4'(pb[mcnt]);
      end else begin
        in_a = 4'($urandom);
        in_b = 4'($urandom);
      end
      if (!done && k > 4000) begin
        check("job_timeout", out_valid, 1);
        done = 1'b1;
      end
    end
    start = 1'b0; in_valid = 1'b0;
    lat = k;
    res = out_psum;
    check("job_result", out_psum, exp_sum);
    for (int h = 0; h < hold; h++) begin
      start = 1'($urandom_range(0, 1));
      len   = 8'($urandom);
      tick();
      check("hold_out_valid", out_valid, 1);
      check("hold_psum", out_psum, exp_sum);
      check("hold_in_ready", in_ready, 0);
      check("hold_busy", busy, 1);
    end
    out_ready = 1'b1; start = 1'b1; len = 8'd3;
    tick();
    check("ack_busy", busy, 0);
    check("ack_out_valid", out_valid, 0);
    check("ack_psum", out_psum, 0);
    check("ack_in_ready", in_ready, 0);
    out_ready = 1'b0; start = 1'b0;
    tick();
    check("ack_start_ignored", busy, 0);
  endtask

  initial begin
    int lat;
    logic [15:0] res;
    int n;

    reset = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b0;
    tick(); tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_psum", out_psum, 0);
    reset = 1'b1;
    tick();

    // Three pairs, no stalls.
    fill_vpat_ones();
    pa[0] = 15; pb[0] = -8;
    pa[1] = 15; pb[1] = -8;
    pa[2] = 1;  pb[2] = 7;
    do_job(3, 0, lat, res);
    check("len3_psum", res, 16'hFF17);
    check("len3_latency", lat, 4);

    // Empty job.
    do_job(0, 0, lat, res);
    check("len0_psum", res, 16'h0000);
    check("len0_latency", lat, 1);

    // Two-cycle gap between the pairs.
    pa[0] = 3; pb[0] = 2;
    pa[1] = 5; pb[1] = -1;
    vpat[1] = 1'b1; vpat[2] = 1'b0; vpat[3] = 1'b0; vpat[4] = 1'b1;
    do_job(2, 0, lat, res);
    check("gap_psum", res, 16'h0001);
    check("gap_latency", lat, 5);
    fill_vpat_ones();

    // Result held while the consumer stalls.
    pa[0] = 4; pb[0] = 5;
    do_job(1, 5, lat, res);
    check("stall_psum", res, 16'd20);

    // Reset in the middle of a four-pair job.
    start = 1'b1; len = 8'd4; in_valid = 1'b1; in_a = 4'd7; in_b = 4'd7;
    tick();
    start = 1'b0;
    tick(); tick();
    check("abort_busy_before", busy, 1);
    reset = 1'b0;
    tick();
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_psum", out_psum, 0);
    reset = 1'b1; in_valid = 1'b0;
    tick();
    pa[0] = 2; pb[0] = 3;
    do_job(1, 0, lat, res);
    check("after_abort_psum", res, 16'h0006);

    // Longest jobs.
    for (int i = 0; i < 255; i++) begin pa[i] = 15; pb[i] = -8; end
    do_job(255, 0, lat, res);
    check("len255_neg_psum", res, 16'h8878);
    check("len255_latency", lat, 256);
    for (int i = 0; i < 255; i++) begin pa[i] = 15; pb[i] = 7; end
    do_job(255, 0, lat, res);
    check("len255_pos_psum", res, 16'h6897);

    // Randomized jobs with random stalls and consumer backpressure.
    for (int j = 0; j < 40; j++) begin
      n = (j % 8 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 20));
      for (int i = 0; i < 256; i++) begin
        pa[i] = int'($urandom_range(0, 15));
        pb[i] = int'($urandom_range(0, 15)) - 8;
      end
      for (int i = 0; i < 4096; i++) vpat[i] = ($urandom_range(0, 3) != 0);
      do_job(n, int'($urandom_range(0, 3)), lat, res);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
